delay_ram_bank: RTL and testbench

// - Four independent delay look-up RAMs, one per DAC port (ports 1..4), 2048 x 24 bit each.
// - Write side is fed by the UART command decoder: per-port write enable, address and 24-bit delay value.
// - Read side is indexed by the per-DAC trigger/transmit ID and returns that ID's delay to the DAC timing logic.
// - Single clock domain; any UART-domain signals are synchronised to I_DELY_CLK upstream of this block.

---
 rtl/delay_ram_bank.sv | 84 ++++++++
 tb/tb_delay_ram_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/delay_ram_bank.sv
// Four independent 2048x24 delay look-up RAMs, one per DAC port, with registered read data.
// Read-first on same-address collisions; define DELAY_RAM_WR_FWD_EN for write-first forwarding.
module delay_ram_bank #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24
) (
  input  logic              I_DELY_CLK,
  input  logic              I_Rst_n,
  input  logic              I_WEA_RAM1,
  input  logic              I_WEA_RAM2,
  input  logic              I_WEA_RAM3,
  input  logic              I_WEA_RAM4,
  input  logic [ADDR_W-1:0] I_WRITE_ADDR_RAM1,
  input  logic [ADDR_W-1:0] I_WRITE_ADDR_RAM2,
  input  logic [ADDR_W-1:0] I_WRITE_ADDR_RAM3,
  input  logic [ADDR_W-1:0] I_WRITE_ADDR_RAM4,
  input  logic [DATA_W-1:0] I_WRITE_DELAY_RAM1,
  input  logic [DATA_W-1:0] I_WRITE_DELAY_RAM2,
  input  logic [DATA_W-1:0] I_WRITE_DELAY_RAM3,
  input  logic [DATA_W-1:0] I_WRITE_DELAY_RAM4,
  input  logic [ADDR_W-1:0] I_READ_ADDR_RAM1,
  input  logic [ADDR_W-1:0] I_READ_ADDR_RAM2,
  input  logic [ADDR_W-1:0] I_READ_ADDR_RAM3,
  input  logic [ADDR_W-1:0] I_READ_ADDR_RAM4,
  output logic [DATA_W-1:0] O_DAC1_DELAY,
  output logic [DATA_W-1:0] O_DAC2_DELAY,
  output logic [DATA_W-1:0] O_DAC3_DELAY,
  output logic [DATA_W-1:0] O_DAC4_DELAY
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              wea   [4];
  logic [ADDR_W-1:0] waddr [4];
  logic [DATA_W-1:0] wdata [4];
  logic [ADDR_W-1:0] raddr [4];

  assign wea[0]   = I_WEA_RAM1;
  assign wea[1]   = I_WEA_RAM2;
  assign wea[2]   = I_WEA_RAM3;
  assign wea[3]   = I_WEA_RAM4;
  assign waddr[0] = I_WRITE_ADDR_RAM1;
  assign waddr[1] = I_WRITE_ADDR_RAM2;
  assign waddr[2] = I_WRITE_ADDR_RAM3;
  assign waddr[3] = I_WRITE_ADDR_RAM4;
  assign wdata[0] = I_WRITE_DELAY_RAM1;
  assign wdata[1] = I_WRITE_DELAY_RAM2;
  assign wdata[2] = I_WRITE_DELAY_RAM3;
  assign wdata[3] = I_WRITE_DELAY_RAM4;
  assign raddr[0] = I_READ_ADDR_RAM1;
  assign raddr[1] = I_READ_ADDR_RAM2;
  assign raddr[2] = I_READ_ADDR_RAM3;
  assign raddr[3] = I_READ_ADDR_RAM4;

  for (genvar g = 0; g < 4; g++) begin : g_ram
    // Power-up contents are zero; reset never touches the array so it stays block RAM.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] q;

    always_ff @(posedge I_DELY_CLK) begin
      if (I_Rst_n && wea[g]) begin
        mem[waddr[g]] <= wdata[g];
      end
    end

    always_ff @(posedge I_DELY_CLK or negedge I_Rst_n) begin
      if (!I_Rst_n) begin
        q <= '0;
`ifdef DELAY_RAM_WR_FWD_EN
      end else if (wea[g] && (waddr[g] == raddr[g])) begin
        q <= wdata[g];
`endif
      end else begin
        q <= mem[raddr[g]];
      end
    end
  end

  assign O_DAC1_DELAY = g_ram[0].q;
  assign O_DAC2_DELAY = g_ram[1].q;
  assign O_DAC3_DELAY = g_ram[2].q;
  assign O_DAC4_DELAY = g_ram[3].q;

endmodule

// File: tb/tb_delay_ram_bank.sv
// Directed bench for delay_ram_bank: a reference memory model feeds a scoreboard queue
// at drive time, and registered outputs are popped and compared one cycle later.
module tb_delay_ram_bank;

  logic        clk;
  logic        rst_n;
  logic        we [4];
  logic [10:0] wa [4];
  logic [23:0] wd [4];
  logic [10:0] ra [4];
  logic [23:0] dac1, dac2, dac3, dac4;

  logic [23:0] mdl [4][2048];
  logic [23:0] sb_q [$];
  int errors = 0;
  int checks = 0;

  delay_ram_bank #(.ADDR_W(11), .DATA_W(24)) dut (
    .I_DELY_CLK(clk), .I_Rst_n(rst_n),
    .I_WEA_RAM1(we[0]), .I_WEA_RAM2(we[1]), .I_WEA_RAM3(we[2]), .I_WEA_RAM4(we[3]),
    .I_WRITE_ADDR_RAM1(wa[0]), .I_WRITE_ADDR_RAM2(wa[1]),
    .I_WRITE_ADDR_RAM3(wa[2]), .I_WRITE_ADDR_RAM4(wa[3]),
    .I_WRITE_DELAY_RAM1(wd[0]), .I_WRITE_DELAY_RAM2(wd[1]),
    .I_WRITE_DELAY_RAM3(wd[2]), .I_WRITE_DELAY_RAM4(wd[3]),
    .I_READ_ADDR_RAM1(ra[0]), .I_READ_ADDR_RAM2(ra[1]),
    .I_READ_ADDR_RAM3(ra[2]), .I_READ_ADDR_RAM4(ra[3]),
    .O_DAC1_DELAY(dac1), .O_DAC2_DELAY(dac2), .O_DAC3_DELAY(dac3), .O_DAC4_DELAY(dac4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] dac(input int n);
    case (n)
      0:       return dac1;
      1:       return dac2;
      2:       return dac3;
      default: return dac4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 4; n++) begin
      we[n] = 1'b0;
      wa[n] = '0;
      wd[n] = '0;
    end
  endtask

  // Called just after a falling edge with inputs already driven; compares one cycle later.
  task automatic step(input string tag);
    logic [23:0] e;
    for (int n = 0; n < 4; n++) begin
      if (!rst_n) e = '0;
      else e = mdl[n][ra[n]];
`ifdef DELAY_RAM_WR_FWD_EN
      if (rst_n && we[n] && wa[n] == ra[n]) e = wd[n];
`endif
      sb_q.push_back(e);
    end
    for (int n = 0; n < 4; n++)
      if (rst_n && we[n]) mdl[n][wa[n]] = wd[n];
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $error("FAIL %s_scoreboard_empty observed=0 expected=1", tag);
      end else begin
        chk($sformatf("%s_dac%0d", tag, n + 1), dac(n), sb_q.pop_front());
      end
    end
  endtask

  task automatic read_all(input string tag, input logic [10:0] a);
    idle_inputs();
    for (int n = 0; n < 4; n++) ra[n] = a;
    step(tag);
  endtask

  initial begin
    for (int n = 0; n < 4; n++)
      for (int a = 0; a < 2048; a++) mdl[n][a] = '0;
    rst_n = 1'b0;
    idle_inputs();
    for (int n = 0; n < 4; n++) ra[n] = '0;

    // Reset held: random read addresses, outputs stay zero
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 4; n++) ra[n] = 11'($urandom_range(2047));
      step("reset_hold");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 4; n++) ra[n] = 11'($urandom_range(2047));
      step("unwritten");
    end

    // Per-port write at address 0, read back
    for (int n = 0; n < 4; n++) begin
      we[n] = 1'b1; wa[n] = '0; wd[n] = 24'(10 * (n + 1)); ra[n] = '0;
    end
    step("wr_addr0");
    read_all("rd_addr0", 11'd0);
    chk("addr0_ram1_const", dac1, 24'h00000A);
    chk("addr0_ram4_const", dac4, 24'h000028);

    // Isolation: RAM2 only
    idle_inputs();
    we[1] = 1'b1; wa[1] = 11'd5; wd[1] = 24'hABCDEF;
    for (int n = 0; n < 4; n++) ra[n] = 11'd9;
    step("iso_wr");
    read_all("iso_rd", 11'd5);
    chk("iso_ram2_const", dac2, 24'hABCDEF);
    chk("iso_ram1_const", dac1, 24'h000000);

    // Boundary addresses on RAM3
    idle_inputs();
    we[2] = 1'b1; wa[2] = 11'd0; wd[2] = 24'h000001;
    step("bnd_wr0");
    idle_inputs();
    we[2] = 1'b1; wa[2] = 11'd2047; wd[2] = 24'hFFFFFF;
    step("bnd_wr2047");
    read_all("bnd_rd0", 11'd0);
    read_all("bnd_rd2047", 11'd2047);
    chk("bnd_ram3_top_const", dac3, 24'hFFFFFF);
    read_all("bnd_rd1", 11'd1);
    read_all("bnd_rd2046", 11'd2046);

    // Same-edge collision on RAM1 address 7
    idle_inputs();
    we[0] = 1'b1; wa[0] = 11'd7; wd[0] = 24'h000011;
    step("col_pre");
    idle_inputs();
    we[0] = 1'b1; wa[0] = 11'd7; wd[0] = 24'h000022;
    for (int n = 0; n < 4; n++) ra[n] = 11'd7;
    step("col_same_edge");
`ifdef DELAY_RAM_WR_FWD_EN
    chk("col_fwd_const", dac1, 24'h000022);
`else
    chk("col_rdfirst_const", dac1, 24'h000011);
`endif
    read_all("col_next", 11'd7);
    chk("col_next_const", dac1, 24'h000022);

    // Reset pulse mid-operation with a pending RAM4 write
    read_all("pre_rst", 11'd0);
    we[3] = 1'b1; wa[3] = 11'd3; wd[3] = 24'h123456;
    #2 rst_n = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) chk($sformatf("async_rst_dac%0d", n + 1), dac(n), 24'h0);
    #27;
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    read_all("post_rst_a3", 11'd3);
    chk("post_rst_ram4_a3_const", dac4, 24'h000000);
    read_all("post_rst_a0", 11'd0);
    read_all("post_rst_a5", 11'd5);
    read_all("post_rst_a7", 11'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
